// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Initiator side of the ALU operand/opcode/result interface. A request
//   (opcode, A, B, extra-pass count) is taken on a valid/ready handshake. The
//   block drives the ALU inputs, waits out the ALU's registered latency, and
//   optionally feeds each result back as the next A. The final result is
//   returned on a valid/ready response port, so callers never track ALU timing.
//
// Ports
//   clk          in   1       clock, rising edge
//   reset        in   1       synchronous reset, active low (0 = reset)
//   req_valid    in   1       request valid
//   req_ready    out  1       request ready (high only in IDLE, out of reset)
//   req_opcode   in   OP_W    ALU opcode used for every pass
//   req_a        in   DATA_W  first-pass operand A
//   req_b        in   DATA_W  operand B, constant across passes
//   req_iter     in   CNT_W   extra passes; total passes = req_iter + 1
//   resp_valid   out  1       response valid
//   resp_ready   in   1       response ready
//   resp_result  out  DATA_W  final ALU result (kept after the handshake)
//   busy         out  1       high in any state other than IDLE
//   alu_a        out  DATA_W  to ALU operand A (registered)
//   alu_b        out  DATA_W  to ALU operand B (registered)
//   alu_op       out  OP_W    to ALU opcode (registered)
//   alu_result   in   DATA_W  from ALU result
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int CNT_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_opcode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [CNT_W-1:0]  req_iter,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result
);

  // The latency counter only ever holds ALU_LAT-1 down to 0.
  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   pass_cnt;
  logic [LAT_W-1:0]   lat_cnt;

  // Ready is gated by reset so the caller never sees an accept window while
  // the block is held in reset.
  assign req_ready = (state == S_IDLE) && reset;

  // NOTE: all state is updated with non-blocking assignments so every register
  // in this block sees the values from before the edge, matching the hardware.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_result <= '0;
      resp_valid  <= 1'b0;
      busy        <= 1'b0;
      pass_cnt    <= '0;
      lat_cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            alu_a    <= req_a;
            alu_b    <= req_b;
            alu_op   <= req_opcode;
            pass_cnt <= req_iter;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end

        // ALU inputs are stable for this cycle; the ALU captures them at the
        // edge that closes it.
        S_ISSUE: begin
          lat_cnt <= LAT_W'(ALU_LAT - 1);
          state   <= S_WAIT;
        end

        // Stays ALU_LAT cycles; the result is taken at the edge ending the
        // last one.
        S_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else if (pass_cnt != '0) begin
            alu_a    <= alu_result;
            pass_cnt <= pass_cnt - 1'b1;
            state    <= S_ISSUE;
          end else begin
            resp_result <= alu_result;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
